spi_reg_cmd_decode: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 36 +++
 rtl/spi_reg_cmd_decode_pin_sync.sv | 41 ++++
 rtl/spi_reg_cmd_decode.sv | 213 +++++++++++++++++++++
 tb/tb_spi_reg_cmd_decode.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the SPI register command decoder:
// field widths, command codes, minimum write-strobe hold and FSM states.
package spi_reg_pkg;

   localparam int SPI_ADDR_LENGTH_DEF = 16;
   localparam int SHORT_REG_WD_DEF    = 16;
   localparam int CMD_WD_DEF          = 8;
   localparam int NUM_LIST_DEF        = 3;
   localparam int RD_SETTLE_DEF       = 4;

   localparam logic [7:0] WR_CMD_DEF = 8'h80;
   localparam logic [7:0] RD_CMD_DEF = 8'h3C;

   // The lists resynchronise o_wr_en into slower clocks, so it never pulses shorter than this.
   localparam int WR_HOLD_MIN = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WR_DATA,
      ST_RD_WAIT,
      ST_RD_SHIFT,
      ST_DONE
   } spi_state_e;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/spi_reg_cmd_decode_pin_sync.sv
`timescale 1ns/1ps
// Brings the asynchronous SPI pins into the clk_sample domain and
// derives single-cycle SCK / CS_n edge pulses from the synchronised samples.
module spi_pin_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sck_i,
   input  logic cs_n_i,
   input  logic mosi_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic mosi_s_o
);

   logic [2:0] sckPipe_q;
   logic [2:0] csPipe_q;
   logic [2:0] mosiPipe_q;

   // Stages [0],[1] form the synchroniser, [2] is the history used for edge detection.
   // CS_n resets high so leaving reset never looks like the start of a frame.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sckPipe_q  <= '0;
         csPipe_q   <= '1;
         mosiPipe_q <= '0;
      end else begin
         sckPipe_q  <= {sckPipe_q[1:0], sck_i};
         csPipe_q   <= {csPipe_q[1:0], cs_n_i};
         mosiPipe_q <= {mosiPipe_q[1:0], mosi_i};
      end
   end

   assign sck_rise_o = sckPipe_q[1] & ~sckPipe_q[2];
   assign sck_fall_o = ~sckPipe_q[1] & sckPipe_q[2];
   assign cs_fall_o  = ~csPipe_q[1] & csPipe_q[2];
   assign cs_rise_o  = csPipe_q[1] & ~csPipe_q[2];
   assign mosi_s_o   = mosiPipe_q[2];

endmodule

// File: rtl/spi_reg_cmd_decode.sv
`timescale 1ns/1ps
// SPI-slave command decoder: parses command/address/data frames from the oversampled pins,
// drives the register-list control levels and returns the selected read word on MISO.
module spi_reg_cmd_decode
   import spi_reg_pkg::*;
#(
   parameter int SPI_ADDR_LENGTH = SPI_ADDR_LENGTH_DEF,
   parameter int SHORT_REG_WD    = SHORT_REG_WD_DEF,
   parameter int CMD_WD          = CMD_WD_DEF,
   parameter int NUM_LIST        = NUM_LIST_DEF,
   parameter int RD_SETTLE       = RD_SETTLE_DEF,
   parameter logic [CMD_WD-1:0] WR_CMD = CMD_WD'(WR_CMD_DEF),
   parameter logic [CMD_WD-1:0] RD_CMD = CMD_WD'(RD_CMD_DEF)
) (
   input  logic                             clk_sample,
   input  logic                             reset_sample_n,
   input  logic                             i_spi_clk,
   input  logic                             i_spi_cs_n,
   input  logic                             i_spi_mosi,
   output logic                             o_spi_miso,
   output logic                             o_wr_en,
   output logic                             o_rd_en,
   output logic                             o_cmd_is_rd,
   output logic [SPI_ADDR_LENGTH-1:0]       ov_addr,
   output logic [SHORT_REG_WD-1:0]          ov_wr_data,
   input  logic [NUM_LIST-1:0]              iv_sel,
   input  logic [NUM_LIST*SHORT_REG_WD-1:0] iv_rd_data
);

   localparam int FIELD_MAX = maxOf3(CMD_WD, SPI_ADDR_LENGTH, SHORT_REG_WD);
   localparam int CNT_W     = $clog2(FIELD_MAX + 1);
   localparam int SET_W     = $clog2(RD_SETTLE + 1);
   localparam int HOLD_W    = $clog2(WR_HOLD_MIN + 1);

   logic sckRise, sckFall, csFall, csRise, mosiS;

   spi_state_e                 state_q;
   logic [CNT_W-1:0]           bitCnt_q, bitCnt_d;
   logic [FIELD_MAX-1:0]       shift_q, shift_d;
   logic [SET_W-1:0]           settle_q;
   logic [HOLD_W-1:0]          hold_q;
   logic                       wrPend_q, wrEn_q, rdEn_q, cmdIsRd_q, miso_q;
   logic [SPI_ADDR_LENGTH-1:0] addr_q;
   logic [SHORT_REG_WD-1:0]    wrData_q;
   logic [SHORT_REG_WD-1:0]    rdWord;

   spi_pin_sync u_pin_sync (
      .clk_i      (clk_sample),
      .rst_ni     (reset_sample_n),
      .sck_i      (i_spi_clk),
      .cs_n_i     (i_spi_cs_n),
      .mosi_i     (i_spi_mosi),
      .sck_rise_o (sckRise),
      .sck_fall_o (sckFall),
      .cs_fall_o  (csFall),
      .cs_rise_o  (csRise),
      .mosi_s_o   (mosiS)
   );

   always_comb begin
      shift_d  = {shift_q[FIELD_MAX-2:0], mosiS};
      bitCnt_d = (bitCnt_q == CNT_W'(FIELD_MAX)) ? bitCnt_q : bitCnt_q + 1'b1;
   end

   // Lists that miss the address drive their sel low; several hits simply OR together.
   always_comb begin
      rdWord = '0;
      for (int k = 0; k < NUM_LIST; k++) begin
         rdWord |= iv_rd_data[k*SHORT_REG_WD +: SHORT_REG_WD] & {SHORT_REG_WD{iv_sel[k]}};
      end
   end

   always_ff @(posedge clk_sample or negedge reset_sample_n) begin
      if (!reset_sample_n) begin
         state_q   <= ST_IDLE;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         settle_q  <= '0;
         hold_q    <= '0;
         wrPend_q  <= 1'b0;
         wrEn_q    <= 1'b0;
         rdEn_q    <= 1'b0;
         cmdIsRd_q <= 1'b0;
         miso_q    <= 1'b0;
         addr_q    <= '0;
         wrData_q  <= '0;
      end else begin
         // The write strobe lives outside the frame FSM so it can outlast an early CS_n release.
         if (wrPend_q) begin
            wrEn_q   <= 1'b1;
            hold_q   <= HOLD_W'(1);
            wrPend_q <= 1'b0;
         end else if (wrEn_q) begin
            if (hold_q < HOLD_W'(WR_HOLD_MIN)) begin
               hold_q <= hold_q + 1'b1;
            end else if (state_q != ST_DONE || csRise) begin
               wrEn_q <= 1'b0;
            end
         end

         if (csRise) begin
            state_q   <= ST_IDLE;
            rdEn_q    <= 1'b0;
            cmdIsRd_q <= 1'b0;
            miso_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (csFall) begin
                     state_q  <= ST_CMD;
                     bitCnt_q <= '0;
                     shift_q  <= '0;
                  end
               end

               ST_CMD: begin
                  if (sckRise) begin
                     if (bitCnt_q == CNT_W'(CMD_WD - 1)) begin
                        bitCnt_q <= '0;
                        shift_q  <= '0;
                        if (shift_d[CMD_WD-1:0] == WR_CMD) begin
                           state_q <= ST_ADDR;
                        end else if (shift_d[CMD_WD-1:0] == RD_CMD) begin
                           state_q   <= ST_ADDR;
                           cmdIsRd_q <= 1'b1;
                        end else begin
                           state_q <= ST_DONE;
                        end
                     end else begin
                        shift_q  <= shift_d;
                        bitCnt_q <= bitCnt_d;
                     end
                  end
               end

               ST_ADDR: begin
                  if (sckRise) begin
                     if (bitCnt_q == CNT_W'(SPI_ADDR_LENGTH - 1)) begin
                        addr_q   <= shift_d[SPI_ADDR_LENGTH-1:0];
                        bitCnt_q <= '0;
                        shift_q  <= '0;
                        if (cmdIsRd_q) begin
                           rdEn_q   <= 1'b1;
                           settle_q <= '0;
                           state_q  <= ST_RD_WAIT;
                        end else begin
                           state_q <= ST_WR_DATA;
                        end
                     end else begin
                        shift_q  <= shift_d;
                        bitCnt_q <= bitCnt_d;
                     end
                  end
               end

               ST_WR_DATA: begin
                  if (sckRise) begin
                     if (bitCnt_q == CNT_W'(SHORT_REG_WD - 1)) begin
                        wrData_q <= shift_d[SHORT_REG_WD-1:0];
                        wrPend_q <= 1'b1;
                        bitCnt_q <= '0;
                        state_q  <= ST_DONE;
                     end else begin
                        shift_q  <= shift_d;
                        bitCnt_q <= bitCnt_d;
                     end
                  end
               end

               ST_RD_WAIT: begin
                  if (settle_q == SET_W'(RD_SETTLE - 1)) begin
                     shift_q  <= FIELD_MAX'(rdWord);
                     miso_q   <= rdWord[SHORT_REG_WD-1];
                     bitCnt_q <= '0;
                     state_q  <= ST_RD_SHIFT;
                  end else begin
                     settle_q <= settle_q + 1'b1;
                  end
               end

               // The MSB is already on MISO; the SCK fall that closes the address is not a shift.
               ST_RD_SHIFT: begin
                  if (sckFall && bitCnt_q != '0) begin
                     shift_q <= shift_q << 1;
                     miso_q  <= shift_q[SHORT_REG_WD-2];
                  end
                  if (sckRise) begin
                     if (bitCnt_q == CNT_W'(SHORT_REG_WD - 1)) begin
                        state_q <= ST_DONE;
                     end else begin
                        bitCnt_q <= bitCnt_d;
                     end
                  end
               end

               ST_DONE: begin
                  state_q <= ST_DONE;
               end

               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_wr_en     = wrEn_q;
   assign o_rd_en     = rdEn_q;
   assign o_cmd_is_rd = cmdIsRd_q;
   assign o_spi_miso  = miso_q;
   assign ov_addr     = addr_q;
   assign ov_wr_data  = wrData_q;

endmodule

// File: tb/tb_spi_reg_cmd_decode.sv
`timescale 1ns/1ps
// Self-checking bench for spi_reg_cmd_decode: directed frame table, hand-written
// corner sequences and random frames checked against a frame-level reference model.
module tb_spi_reg_cmd_decode;

   localparam logic [7:0] WR = 8'h80;
   localparam logic [7:0] RD = 8'h3C;

   logic        clk_sample = 1'b0;
   logic        reset_sample_n;
   logic        i_spi_clk, i_spi_cs_n, i_spi_mosi;
   logic        o_spi_miso, o_wr_en, o_rd_en, o_cmd_is_rd;
   logic [15:0] ov_addr, ov_wr_data;
   logic [2:0]  iv_sel;
   logic [47:0] iv_rd_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] addr;
      logic [15:0] data;
      int          nBits;
      logic [2:0]  sel;
      logic [47:0] rdData;
      logic        expWr;
      logic        expRd;
      logic        expCmdRd;
      logic [15:0] expMiso;
      logic [15:0] expAddr;
      logic [15:0] expData;
   } vec_t;

   vec_t vecs[8];

   logic [15:0] modelAddr = '0;
   logic [15:0] modelData = '0;

   spi_reg_cmd_decode dut (
      .clk_sample     (clk_sample),
      .reset_sample_n (reset_sample_n),
      .i_spi_clk      (i_spi_clk),
      .i_spi_cs_n     (i_spi_cs_n),
      .i_spi_mosi     (i_spi_mosi),
      .o_spi_miso     (o_spi_miso),
      .o_wr_en        (o_wr_en),
      .o_rd_en        (o_rd_en),
      .o_cmd_is_rd    (o_cmd_is_rd),
      .ov_addr        (ov_addr),
      .ov_wr_data     (ov_wr_data),
      .iv_sel         (iv_sel),
      .iv_rd_data     (iv_rd_data)
   );

   always #5 clk_sample = ~clk_sample;

   // Passive monitor sampling on the falling clock edge: counts strobe pulses and records write pulses.
   int          wrRises = 0, rdRises = 0, cmdHigh = 0, wrStableBad = 0;
   int          wrCurLen = 0, wrLastLen = 0;
   logic [15:0] wrLastAddr = '0, wrLastData = '0, prevAddr = '0, prevData = '0;
   logic        prevWr = 1'b0, prevRd = 1'b0;

   always @(negedge clk_sample) begin
      if (o_wr_en && !prevWr) begin
         wrRises++;
         wrLastAddr = ov_addr;
         wrLastData = ov_wr_data;
         if (ov_addr !== prevAddr || ov_wr_data !== prevData) wrStableBad++;
         wrCurLen = 0;
      end
      if (o_wr_en) wrCurLen++;
      if (!o_wr_en && prevWr) wrLastLen = wrCurLen;
      if (o_rd_en && !prevRd) rdRises++;
      if (o_cmd_is_rd) cmdHigh++;
      prevWr   = o_wr_en;
      prevRd   = o_rd_en;
      prevAddr = ov_addr;
      prevData = ov_wr_data;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
      end
   endtask

   // Word a read returns: the data of every list that claims the address, OR-ed together.
   function automatic logic [15:0] refReadWord(input logic [2:0] sel, input logic [47:0] rd);
      logic [15:0] w;
      w = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         if (sel[k]) w = w | rd[k*16 +: 16];
      end
      return w;
   endfunction

   function automatic vec_t mkVec(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] data,
                                  input int nBits, input logic [2:0] sel, input logic [47:0] rd,
                                  input logic eWr, input logic eRd, input logic eCmdRd,
                                  input logic [15:0] eMiso, input logic [15:0] eAddr, input logic [15:0] eData);
      vec_t v;
      v.cmd = cmd; v.addr = addr; v.data = data; v.nBits = nBits; v.sel = sel; v.rdData = rd;
      v.expWr = eWr; v.expRd = eRd; v.expCmdRd = eCmdRd;
      v.expMiso = eMiso; v.expAddr = eAddr; v.expData = eData;
      return v;
   endfunction

   // Frame-level model: what a host transaction of nBits bits should leave behind.
   function automatic vec_t modelFrame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] data,
                                       input int nBits, input logic [2:0] sel, input logic [47:0] rd);
      logic isWr, isRd, addrDone;
      isWr     = (cmd == WR);
      isRd     = (cmd == RD);
      addrDone = (isWr || isRd) && nBits >= 24;
      return mkVec(cmd, addr, data, nBits, sel, rd,
                   isWr && nBits == 40, isRd && nBits >= 24, isRd && nBits >= 8,
                   refReadWord(sel, rd), addrDone ? addr : modelAddr,
                   (isWr && nBits == 40) ? data : modelData);
   endfunction

   task automatic spiBit(input logic b, input int extraHigh, output logic misoSeen);
      i_spi_mosi = b;
      #50;
      misoSeen = o_spi_miso;
      i_spi_clk = 1'b1;
      #(50 + extraHigh);
      i_spi_clk = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] data,
                                input int nBits, input bit earlyCs,
                                output logic [15:0] misoWord, output logic cmdMid, output logic rdMid);
      logic [39:0] frame;
      logic        m;
      frame    = {cmd, addr, data};
      misoWord = '0;
      cmdMid   = 1'b0;
      rdMid    = 1'b0;
      @(negedge clk_sample);
      i_spi_cs_n = 1'b0;
      #100;
      for (int i = 0; i < nBits; i++) begin
         if (i == 16) begin
            cmdMid = o_cmd_is_rd;
            rdMid  = o_rd_en;
         end
         if (earlyCs && i == nBits - 1) begin
            i_spi_mosi = frame[39-i];
            #50;
            i_spi_clk = 1'b1;
            #20;
            i_spi_cs_n = 1'b1;
            #30;
            i_spi_clk = 1'b0;
         end else begin
            spiBit(frame[39-i], (i == 23 && cmd == RD) ? 200 : 0, m);
            if (i >= 24) misoWord = {misoWord[14:0], m};
         end
      end
      if (!earlyCs) begin
         #100;
         i_spi_cs_n = 1'b1;
      end
      i_spi_mosi = 1'b0;
      #500;
   endtask

   task automatic runAndCheck(input string tag, input vec_t v);
      int          wr0, rd0, cmd0, st0;
      logic [15:0] mw;
      logic        cm, rm;
      wr0 = wrRises; rd0 = rdRises; cmd0 = cmdHigh; st0 = wrStableBad;
      iv_sel     = v.sel;
      iv_rd_data = v.rdData;
      applyStimulus(v.cmd, v.addr, v.data, v.nBits, 1'b0, mw, cm, rm);
      checkOutput({tag, " wr_pulses"}, wrRises - wr0, v.expWr);
      if (v.expWr) begin
         checkOutput({tag, " wr_addr"}, wrLastAddr, v.addr);
         checkOutput({tag, " wr_data"}, wrLastData, v.data);
         checkOutput({tag, " wr_len_ge4"}, wrLastLen >= 4, 1'b1);
         checkOutput({tag, " wr_stable"}, wrStableBad - st0, 0);
      end
      checkOutput({tag, " rd_pulses"}, rdRises - rd0, v.expRd);
      checkOutput({tag, " cmd_is_rd_seen"}, (cmdHigh - cmd0) > 0, v.expCmdRd);
      if (v.nBits > 16) begin
         checkOutput({tag, " cmd_is_rd_mid"}, cm, v.cmd == RD);
         checkOutput({tag, " rd_en_mid"}, rm, 1'b0);
      end
      if (v.expRd && v.nBits == 40) checkOutput({tag, " miso_word"}, mw, v.expMiso);
      checkOutput({tag, " addr_after"}, ov_addr, v.expAddr);
      checkOutput({tag, " data_after"}, ov_wr_data, v.expData);
      checkOutput({tag, " clear_after_cs"}, {o_wr_en, o_rd_en, o_cmd_is_rd, o_spi_miso}, 4'b0000);
      modelAddr = v.expAddr;
      modelData = v.expData;
   endtask

   initial begin
      logic [15:0] mw;
      logic        cm, rm, m;
      logic [39:0] frame;
      int          wr0, rd0, cmd0, st0, nb;
      logic [7:0]  c;

      reset_sample_n = 1'b0;
      i_spi_cs_n = 1'b1; i_spi_clk = 1'b0; i_spi_mosi = 1'b0;
      iv_sel = '0; iv_rd_data = '0;
      #23;
      checkOutput("reset wr_en", o_wr_en, 1'b0);
      checkOutput("reset rd_en", o_rd_en, 1'b0);
      checkOutput("reset cmd_is_rd", o_cmd_is_rd, 1'b0);
      checkOutput("reset miso", o_spi_miso, 1'b0);
      checkOutput("reset addr", ov_addr, 16'h0);
      checkOutput("reset data", ov_wr_data, 16'h0);
      @(negedge clk_sample);
      reset_sample_n = 1'b1;
      #50;

      vecs[0] = mkVec(WR, 16'h0044, 16'h0005, 40, 3'b000, 48'h0, 1, 0, 0, 16'h0000, 16'h0044, 16'h0005);
      vecs[1] = mkVec(RD, 16'h00A0, 16'h0000, 40, 3'b010, 48'h5555_0001_FFFF, 0, 1, 1, 16'h0001, 16'h00A0, 16'h0005);
      vecs[2] = mkVec(RD, 16'h1234, 16'h0000, 40, 3'b000, 48'hAAAA_BBBB_CCCC, 0, 1, 1, 16'h0000, 16'h1234, 16'h0005);
      vecs[3] = mkVec(8'h55, 16'hBEEF, 16'h1111, 40, 3'b111, 48'hFFFF_FFFF_FFFF, 0, 0, 0, 16'h0000, 16'h1234, 16'h0005);
      vecs[4] = mkVec(WR, 16'h0777, 16'h0999, 30, 3'b000, 48'h0, 0, 0, 0, 16'h0000, 16'h0777, 16'h0005);
      vecs[5] = mkVec(WR, 16'h0055, 16'hAA55, 40, 3'b000, 48'h0, 1, 0, 0, 16'h0000, 16'h0055, 16'hAA55);
      vecs[6] = mkVec(RD, 16'h0BCD, 16'h0000, 40, 3'b101, 48'h0F0F_1234_F0F0, 0, 1, 1, 16'hFFFF, 16'h0BCD, 16'hAA55);
      vecs[7] = mkVec(RD, 16'h9999, 16'h0000, 12, 3'b001, 48'h0000_0000_1111, 0, 0, 1, 16'h0000, 16'h0BCD, 16'hAA55);

      for (int i = 0; i < 8; i++) runAndCheck($sformatf("vec%0d", i), vecs[i]);

      // CS_n released two samples after the last data bit: strobe must still last exactly the minimum.
      wr0 = wrRises; st0 = wrStableBad;
      applyStimulus(WR, 16'h0ABC, 16'h0DEF, 40, 1'b1, mw, cm, rm);
      checkOutput("early_cs wr_pulses", wrRises - wr0, 1);
      checkOutput("early_cs wr_len", wrLastLen, 4);
      checkOutput("early_cs wr_addr", wrLastAddr, 16'h0ABC);
      checkOutput("early_cs wr_data", wrLastData, 16'h0DEF);
      checkOutput("early_cs wr_stable", wrStableBad - st0, 0);
      checkOutput("early_cs clear", {o_wr_en, o_rd_en, o_cmd_is_rd, o_spi_miso}, 4'b0000);
      modelAddr = 16'h0ABC;
      modelData = 16'h0DEF;

      // Reset in the middle of shifting out a read word.
      iv_sel = 3'b010;
      iv_rd_data = 48'h0000_FFFF_0000;
      frame = {RD, 16'h0042, 16'h0000};
      @(negedge clk_sample);
      i_spi_cs_n = 1'b0;
      #100;
      for (int i = 0; i < 28; i++) spiBit(frame[39-i], (i == 23) ? 200 : 0, m);
      #50;
      checkOutput("pre_reset rd_en", o_rd_en, 1'b1);
      checkOutput("pre_reset miso", o_spi_miso, 1'b1);
      #3;
      reset_sample_n = 1'b0;
      #1;
      checkOutput("mid_reset wr_en", o_wr_en, 1'b0);
      checkOutput("mid_reset rd_en", o_rd_en, 1'b0);
      checkOutput("mid_reset cmd_is_rd", o_cmd_is_rd, 1'b0);
      checkOutput("mid_reset miso", o_spi_miso, 1'b0);
      checkOutput("mid_reset addr", ov_addr, 16'h0);
      i_spi_cs_n = 1'b1;
      #36;
      reset_sample_n = 1'b1;
      modelAddr = '0;
      modelData = '0;
      #100;
      wr0 = wrRises; rd0 = rdRises; cmd0 = cmdHigh;
      frame = {WR, 16'h0011, 16'h0022};
      for (int i = 0; i < 40; i++) spiBit(frame[39-i], 0, m);
      #300;
      checkOutput("cs_high_sck wr_pulses", wrRises - wr0, 0);
      checkOutput("cs_high_sck rd_pulses", rdRises - rd0, 0);
      checkOutput("cs_high_sck cmd_is_rd", cmdHigh - cmd0, 0);
      checkOutput("cs_high_sck addr", ov_addr, 16'h0);
      runAndCheck("post_reset_wr", modelFrame(WR, 16'h0011, 16'h0022, 40, 3'b000, 48'h0));

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 2))
            0: c = WR;
            1: c = RD;
            default: begin
               c = 8'($urandom_range(0, 255));
               if (c == WR || c == RD) c = c ^ 8'h01;
            end
         endcase
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : 40;
         runAndCheck($sformatf("rand%0d", n),
                     modelFrame(c, 16'($urandom), 16'($urandom), nb, 3'($urandom),
                                {16'($urandom), 16'($urandom), 16'($urandom)}));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
